// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader.
// Loads a length-prefixed little-endian byte stream into instruction memory.
package imem_loader_pkg;

    localparam int DEFAULT_DEPTH_WORDS = 64;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
// The master modport is the loader side; the slave modport is the environment side.
interface imem_loader_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

endinterface

// File: rtl/word_assembler.sv
// Collects four accepted bytes, least significant first, into one 32-bit word.
// word_complete pulses combinationally on the fourth byte together with the full word.
module word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic        word_complete,
    output logic [31:0] word_out
);

    logic [1:0]  byte_cnt;
    logic [31:0] shreg;

    // Partial bytes stay in shreg across input gaps; only clear or reset discards them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= 2'd0;
            shreg    <= 32'd0;
        end else if (clear) begin
            byte_cnt <= 2'd0;
            shreg    <= 32'd0;
        end else if (accept) begin
            shreg[8*byte_cnt +: 8] <= byte_in;
            byte_cnt               <= byte_cnt + 2'd1;
        end
    end

    always_comb begin
        word_complete = accept && (byte_cnt == 2'd3);
        word_out      = {byte_in, shreg[23:0]};
    end

endmodule

// File: rtl/imem_loader.sv
// Loader FSM: reads a 16-bit word count, then streams words into instruction
// memory while holding the core in reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int CNT_W       = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          cpu_rst_n,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [CNT_W-1:0] DEPTH_N = CNT_W'(DEPTH_WORDS);

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic               asm_accept;
    logic               start_ok;
    logic               len_cnt;
    logic [7:0]         len_lo;
    logic [15:0]        len_full;
    logic [CNT_W-1:0]   n_next;
    logic [CNT_W-1:0]   n_words;
    logic [CNT_W-1:0]   word_idx;
    logic               last_word;
    logic               word_complete;
    logic [31:0]        asm_word;

    assign accept     = bus.rx_valid && bus.rx_ready;
    assign asm_accept = accept && (state == DATA);
    assign start_ok   = start && (state == IDLE || state == DONE || state == ERR);
    assign len_full   = {bus.rx_data, len_lo};
    assign n_next     = CNT_W'(len_full);
    assign last_word  = word_complete && (word_idx == n_words - 1'b1);

    word_assembler u_asm (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (start_ok),
        .accept        (asm_accept),
        .byte_in       (bus.rx_data),
        .word_complete (word_complete),
        .word_out      (asm_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // The last word's write strobe and the move to DONE land on the same edge.
    always_comb begin
        state_next   = state;
        bus.rx_ready = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        cpu_rst_n    = 1'b0;
        case (state)
            IDLE: begin
                cpu_rst_n = rst_n;
                if (start) state_next = LEN;
            end
            LEN: begin
                bus.rx_ready = 1'b1;
                busy         = 1'b1;
                if (accept && len_cnt) begin
                    if (n_next == '0)          state_next = DONE;
                    else if (n_next > DEPTH_N) state_next = ERR;
                    else                       state_next = DATA;
                end
            end
            DATA: begin
                bus.rx_ready = 1'b1;
                busy         = 1'b1;
                if (last_word) state_next = DONE;
            end
            DONE: begin
                done      = 1'b1;
                cpu_rst_n = rst_n;
                if (start) state_next = LEN;
            end
            ERR: begin
                err = 1'b1;
                if (start) state_next = LEN;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_cnt       <= 1'b0;
            len_lo        <= 8'd0;
            n_words       <= '0;
            word_idx      <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 32'd0;
            bus.mem_wdata <= 32'd0;
        end else begin
            bus.mem_we <= 1'b0;
            if (start_ok) begin
                len_cnt  <= 1'b0;
                len_lo   <= 8'd0;
                n_words  <= '0;
                word_idx <= '0;
            end else if (state == LEN && accept) begin
                if (!len_cnt) begin
                    len_lo  <= bus.rx_data;
                    len_cnt <= 1'b1;
                end else begin
                    n_words <= n_next;
                    len_cnt <= 1'b0;
                end
            end else if (asm_accept && word_complete) begin
                bus.mem_we    <= 1'b1;
                bus.mem_addr  <= 32'({word_idx, 2'b00});
                bus.mem_wdata <= asm_word;
                word_idx      <= word_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: nominal, empty, oversize, stalled, full-depth
// and mid-load reset scenarios with hand-computed expectations.
module tb_imem_loader;

    logic clk;
    logic rst_n;
    logic start;
    logic cpu_rst_n;
    logic busy;
    logic done;
    logic err;

    int pass_count;
    int check_count;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    imem_loader_if bus ();

    imem_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus.master),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each write strobe spans one full cycle, so the falling edge sees it once.
    always @(negedge clk) begin
        if (bus.mem_we) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_wdata);
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    endtask

    initial begin
        int bad;
        pass_count   = 0;
        check_count  = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;

        tick(3);
        checkOutput("reset_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        checkOutput("reset_rx_ready", 32'(bus.rx_ready), 32'd0);
        checkOutput("reset_mem_we", 32'(bus.mem_we), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("idle_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        checkOutput("idle_flags", {29'd0, busy, done, err}, 32'd0);

        $display("[TB] nominal load");
        wr_addr_q.delete();
        wr_data_q.delete();
        pulseStart();
        checkOutput("len_busy", 32'(busy), 32'd1);
        checkOutput("len_rx_ready", 32'(bus.rx_ready), 32'd1);
        checkOutput("len_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        applyStimulus(8'h02); applyStimulus(8'h00);
        applyStimulus(8'h13); applyStimulus(8'h05); applyStimulus(8'h30); applyStimulus(8'h00);
        applyStimulus(8'h93); applyStimulus(8'h05); applyStimulus(8'h40); applyStimulus(8'h00);
        checkOutput("nom_last_we_with_done", {30'd0, bus.mem_we, done}, 32'd3);
        tick();
        checkOutput("nom_write_count", 32'(wr_addr_q.size()), 32'd2);
        if (wr_addr_q.size() == 2) begin
            checkOutput("nom_addr0", wr_addr_q[0], 32'h0);
            checkOutput("nom_data0", wr_data_q[0], 32'h00300513);
            checkOutput("nom_addr1", wr_addr_q[1], 32'h4);
            checkOutput("nom_data1", wr_data_q[1], 32'h00400593);
        end
        checkOutput("nom_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        checkOutput("nom_busy", 32'(busy), 32'd0);
        tick(3);
        checkOutput("nom_addr_hold", bus.mem_addr, 32'h4);
        checkOutput("nom_data_hold", bus.mem_wdata, 32'h00400593);

        $display("[TB] empty load");
        wr_addr_q.delete();
        wr_data_q.delete();
        pulseStart();
        checkOutput("empty_done_cleared", 32'(done), 32'd0);
        applyStimulus(8'h00); applyStimulus(8'h00);
        tick();
        checkOutput("empty_done", 32'(done), 32'd1);
        checkOutput("empty_err", 32'(err), 32'd0);
        checkOutput("empty_no_write", 32'(wr_addr_q.size()), 32'd0);

        $display("[TB] oversize load");
        pulseStart();
        applyStimulus(8'h41); applyStimulus(8'h00);
        checkOutput("over_err", 32'(err), 32'd1);
        checkOutput("over_rx_ready", 32'(bus.rx_ready), 32'd0);
        checkOutput("over_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        checkOutput("over_done", 32'(done), 32'd0);
        pulseStart();
        checkOutput("over_err_cleared", 32'(err), 32'd0);
        applyStimulus(8'h01); applyStimulus(8'h00);
        applyStimulus(8'hEF); applyStimulus(8'hBE); applyStimulus(8'hAD); applyStimulus(8'hDE);
        tick();
        checkOutput("over_retry_count", 32'(wr_addr_q.size()), 32'd1);
        if (wr_addr_q.size() == 1) begin
            checkOutput("over_retry_addr", wr_addr_q[0], 32'h0);
            checkOutput("over_retry_data", wr_data_q[0], 32'hDEADBEEF);
        end
        checkOutput("over_retry_done", 32'(done), 32'd1);

        $display("[TB] stalled load");
        wr_addr_q.delete();
        wr_data_q.delete();
        pulseStart();
        applyStimulus(8'h01); tick(5);
        applyStimulus(8'h00); tick(5);
        applyStimulus(8'h78); tick(5);
        applyStimulus(8'h56); tick(5);
        applyStimulus(8'h34); tick(5);
        checkOutput("stall_no_early_write", 32'(wr_addr_q.size()), 32'd0);
        applyStimulus(8'h12); tick(5);
        checkOutput("stall_write_count", 32'(wr_addr_q.size()), 32'd1);
        if (wr_data_q.size() == 1)
            checkOutput("stall_data", wr_data_q[0], 32'h12345678);
        checkOutput("stall_done", 32'(done), 32'd1);

        $display("[TB] full depth load");
        wr_addr_q.delete();
        wr_data_q.delete();
        pulseStart();
        applyStimulus(8'h40); applyStimulus(8'h00);
        for (int i = 0; i < 64; i++) begin
            applyStimulus(8'(i));
            if (i == 32) start = 1'b1;
            applyStimulus(8'h00);
            start = 1'b0;
            applyStimulus(8'h00);
            applyStimulus(8'h00);
        end
        tick();
        checkOutput("full_write_count", 32'(wr_addr_q.size()), 32'd64);
        bad = 0;
        for (int i = 0; i < wr_addr_q.size(); i++)
            if (wr_addr_q[i] !== 32'(4 * i) || wr_data_q[i] !== 32'(i)) bad++;
        checkOutput("full_word_errors", 32'(bad), 32'd0);
        if (wr_addr_q.size() == 64)
            checkOutput("full_last_addr", wr_addr_q[63], 32'hFC);
        checkOutput("full_done", 32'(done), 32'd1);

        $display("[TB] reset mid-load");
        wr_addr_q.delete();
        wr_data_q.delete();
        pulseStart();
        applyStimulus(8'h02); applyStimulus(8'h00);
        applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33);
        applyStimulus(8'h44); applyStimulus(8'h55); applyStimulus(8'h66);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_rx_ready", 32'(bus.rx_ready), 32'd0);
        checkOutput("rst_mid_mem_we", 32'(bus.mem_we), 32'd0);
        checkOutput("rst_mid_mem_addr", bus.mem_addr, 32'd0);
        checkOutput("rst_mid_mem_wdata", bus.mem_wdata, 32'd0);
        checkOutput("rst_mid_flags", {29'd0, busy, done, err}, 32'd0);
        checkOutput("rst_mid_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        tick(2);
        rst_n = 1'b1;
        applyStimulus(8'h77); applyStimulus(8'h88);
        tick(3);
        checkOutput("rst_after_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        checkOutput("rst_after_flags", {29'd0, busy, done, err}, 32'd0);
        checkOutput("rst_after_write_count", 32'(wr_addr_q.size()), 32'd1);
        if (wr_data_q.size() == 1)
            checkOutput("rst_kept_word", wr_data_q[0], 32'h44332211);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
